reaction_timer_ctrl: RTL and testbench
======================================

REACTION_TIMER_CTRL -- requirements
Module: reaction_timer_ctrl

Interface
REQ-001 Parameter N_LIGHTS, default 10, number of starting lights driven on ledr.
REQ-002 Parameter LFSR_BITS, default 5, width of random delay input prbs.
REQ-003 Parameter COUNT_BITS, default 16, width of reaction-time counters.
REQ-004 Parameter MAX_MS, default 9999, saturation value of measured reaction time in ms.
REQ-005 clk  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-006 rst_n  input  1  synchronous, active-low reset.
REQ-007 tick_ms  input  1  one-clk-wide enable pulse every 1 ms.
REQ-008 tick_hs  input  1  one-clk-wide enable pulse every 0.5 s, coincident with a tick_ms.
REQ-009 trigger  input  1  start button, active-high level, synchronous to clk.
REQ-010 react  input  1  reaction button, active-high level, synchronous to clk.
REQ-011 prbs  input  LFSR_BITS  random value from external LFSR.
REQ-012 en_lfsr  output  1  LFSR advance enable.
REQ-013 ledr  output  N_LIGHTS  starting lights, bit 0 lit first.
REQ-014 reaction_ms  output  COUNT_BITS  last measured reaction time.
REQ-015 result_valid  output  1  high while reaction_ms holds a valid result.
REQ-016 false_start  output  1  high while in FAULT.
REQ-017 best_ms  output  COUNT_BITS  best (minimum) valid reaction time since reset.

Function
REQ-018 Rising edges of trigger and react SHALL be detected internally; a level held high SHALL count as one event.
REQ-019 FSM states SHALL be IDLE, LIGHTS, DELAY, TIMING, DONE, FAULT.
REQ-020 IDLE: ledr=0, en_lfsr=1; trigger edge -> LIGHTS, ledr cleared, result_valid=0, reaction_ms unchanged.
REQ-021 LIGHTS: on each tick_hs, ledr shifts in a 1 at bit 0 side (ledr <= {ledr[N-2:0],1}); when ledr becomes all-ones, prbs SHALL be latched on that same clk and state -> DELAY.
REQ-022 en_lfsr SHALL be 1 only in IDLE, DONE and FAULT; 0 in LIGHTS, DELAY, TIMING.
REQ-023 DELAY: latched value D counts down on tick_hs; D=0 SHALL be treated as 1; on final tick_hs ledr <= 0 and state -> TIMING with ms counter cleared to 0 on that clk.
REQ-024 TIMING: ms counter increments on each tick_ms; react edge -> DONE, reaction_ms <= counter, result_valid <= 1 on next clk.
REQ-025 TIMING saturation: counter reaching MAX_MS SHALL -> DONE with reaction_ms=MAX_MS, result_valid=1.
REQ-026 react edge in LIGHTS or DELAY SHALL -> FAULT: false_start=1, ledr=all-ones, result_valid=0.
REQ-027 DONE and FAULT: trigger edge -> LIGHTS as in REQ-020 (false_start cleared); react edges ignored.
REQ-028 Simultaneous react and tick_ms in TIMING: react wins, reaction_ms = counter before increment.
REQ-029 Simultaneous trigger and react edges: trigger SHALL be ignored outside IDLE/DONE/FAULT; in those states trigger wins.
REQ-030 Outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-031 rst_n=0 at clk edge SHALL force IDLE from any state, ledr=0, en_lfsr=1, reaction_ms=0, result_valid=0, false_start=0, best_ms=all-ones (when enabled), counters and edge-detect history cleared.
REQ-032 Edge detectors SHALL not report an event on the first clk after reset even if a button is held.

Configuration
REQ-033 Macro RTC_BEST_TIME_EN defined: best_ms updates to reaction_ms on entry to DONE when new value < best_ms, excluding saturated results.
REQ-034 Macro undefined: best_ms SHALL be tied to 0 and no best-time register synthesised.

Structure
REQ-035 Package reaction_pkg SHALL hold the state enum, default widths and MAX_MS constant.
REQ-036 One sub-module, rise_detect, SHALL implement REQ-018/REQ-032, instantiated once per button.

Verification
REQ-037 Reset, trigger, 10 tick_hs -> ledr 0x001..0x3FF one bit per tick, then DELAY with en_lfsr=0.
REQ-038 prbs=3 at latch, react 250 tick_ms after lights out -> ledr=0 after 3 tick_hs, reaction_ms=250, result_valid=1.
REQ-039 react during DELAY -> false_start=1, ledr=0x3FF, result_valid=0; trigger then restarts LIGHTS.
REQ-040 No react in TIMING -> reaction_ms=9999 after 9999 tick_ms, result_valid=1; prbs=0 latched gives 1-tick_hs delay.
REQ-041 With RTC_BEST_TIME_EN, runs of 300, 200, 400 ms -> best_ms=200; rst_n low mid-TIMING -> IDLE, all outputs at reset values next clk.

Source files
------------

// File: rtl/reaction_pkg.sv
// ----------------------------------------------------------------------------
// reaction_pkg
// Shared types and default sizing for the reaction timer controller.
//   state_t        : controller FSM state encoding
//   *_DEF          : default parameter values used by reaction_timer_ctrl
// ----------------------------------------------------------------------------
package reaction_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LIGHTS = 3'd1,
        DELAY  = 3'd2,
        TIMING = 3'd3,
        DONE   = 3'd4,
        FAULT  = 3'd5
    } state_t;

    localparam int N_LIGHTS_DEF   = 10;
    localparam int LFSR_BITS_DEF  = 5;
    localparam int COUNT_BITS_DEF = 16;
    localparam int MAX_MS_DEF     = 9999;

endpackage

// File: rtl/rise_detect.sv
// ----------------------------------------------------------------------------
// rise_detect
// Rising-edge detector for a synchronous button level. A level held high
// produces a single event. The detector stays disarmed for the first clock
// after reset so a button held through reset is never reported as a press.
// Ports:
//   clk    in  system clock
//   rst_n  in  synchronous active-low reset
//   level  in  button level (already synchronous to clk)
//   rise   out one-clk event on a 0->1 transition of level
// ----------------------------------------------------------------------------
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic rise
);

    logic level_q;
    logic armed;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            armed   <= 1'b0;
        end else begin
            level_q <= level;
            armed   <= 1'b1;
        end
    end

    assign rise = armed & level & ~level_q;

endmodule

// File: rtl/reaction_timer_ctrl.sv
// ----------------------------------------------------------------------------
// reaction_timer_ctrl
// Starting-lights reaction timer. A trigger press fills the lights one per
// half second, waits a random number of half seconds, turns the lights off
// and measures the time in ms until the react press. Pressing react before
// lights-out is a false start.
// Optional feature: define RTC_BEST_TIME_EN to keep the best (minimum)
// non-saturated reaction time in best_ms; otherwise best_ms is tied to 0.
// Ports:
//   clk, rst_n    system clock, synchronous active-low reset
//   tick_ms       1 ms enable pulse
//   tick_hs       0.5 s enable pulse (coincides with a tick_ms)
//   trigger       start button level
//   react         reaction button level
//   prbs          random delay value from external LFSR
//   en_lfsr       LFSR advance enable (registered)
//   ledr          starting lights, bit 0 lit first (registered)
//   reaction_ms   last measured reaction time (registered)
//   result_valid  reaction_ms holds a valid result (registered)
//   false_start   controller is in FAULT (registered)
//   best_ms       best reaction time since reset
// ----------------------------------------------------------------------------
module reaction_timer_ctrl
    import reaction_pkg::*;
#(
    parameter int N_LIGHTS   = N_LIGHTS_DEF,
    parameter int LFSR_BITS  = LFSR_BITS_DEF,
    parameter int COUNT_BITS = COUNT_BITS_DEF,
    parameter int MAX_MS     = MAX_MS_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick_ms,
    input  logic                  tick_hs,
    input  logic                  trigger,
    input  logic                  react,
    input  logic [LFSR_BITS-1:0]  prbs,
    output logic                  en_lfsr,
    output logic [N_LIGHTS-1:0]   ledr,
    output logic [COUNT_BITS-1:0] reaction_ms,
    output logic                  result_valid,
    output logic                  false_start,
    output logic [COUNT_BITS-1:0] best_ms
);

    logic                  trig_rise;
    logic                  react_rise;
    state_t                state;
    logic [LFSR_BITS-1:0]  delay_cnt;
    logic [COUNT_BITS-1:0] ms_cnt;
    logic [N_LIGHTS-1:0]   ledr_shift;

    rise_detect u_trig_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .level (trigger),
        .rise  (trig_rise)
    );

    rise_detect u_react_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .level (react),
        .rise  (react_rise)
    );

    // Next light pattern: shift a 1 in from the bit-0 side.
    assign ledr_shift = (ledr << 1) | N_LIGHTS'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            ledr         <= '0;
            en_lfsr      <= 1'b1;
            reaction_ms  <= '0;
            result_valid <= 1'b0;
            false_start  <= 1'b0;
            delay_cnt    <= '0;
            ms_cnt       <= '0;
`ifdef RTC_BEST_TIME_EN
            best_ms      <= '1;
`endif
        end else begin
            unique case (state)
                // Trigger is only honoured here, so it also wins over a
                // simultaneous react press in these states.
                IDLE, DONE, FAULT: begin
                    if (trig_rise) begin
                        state        <= LIGHTS;
                        ledr         <= '0;
                        en_lfsr      <= 1'b0;
                        result_valid <= 1'b0;
                        false_start  <= 1'b0;
                    end
                end

                LIGHTS, DELAY: begin
                    if (react_rise) begin
                        state        <= FAULT;
                        ledr         <= '1;
                        en_lfsr      <= 1'b1;
                        result_valid <= 1'b0;
                        false_start  <= 1'b1;
                    end else if (tick_hs) begin
                        if (state == LIGHTS) begin
                            ledr <= ledr_shift;
                            // Latch the delay on the clk the lights fill;
                            // a zero delay is stretched to one half second.
                            if (&ledr_shift) begin
                                delay_cnt <= (prbs == '0) ? LFSR_BITS'(1) : prbs;
                                state     <= DELAY;
                            end
                        end else if (delay_cnt <= LFSR_BITS'(1)) begin
                            ledr   <= '0;
                            ms_cnt <= '0;
                            state  <= TIMING;
                        end else begin
                            delay_cnt <= delay_cnt - LFSR_BITS'(1);
                        end
                    end
                end

                TIMING: begin
                    // react takes priority so a coincident tick_ms is not
                    // counted in the result.
                    if (react_rise) begin
                        state        <= DONE;
                        reaction_ms  <= ms_cnt;
                        result_valid <= 1'b1;
                        en_lfsr      <= 1'b1;
`ifdef RTC_BEST_TIME_EN
                        if (ms_cnt < best_ms) begin
                            best_ms <= ms_cnt;
                        end
`endif
                    end else if (tick_ms) begin
                        if (ms_cnt == COUNT_BITS'(MAX_MS - 1)) begin
                            state        <= DONE;
                            reaction_ms  <= COUNT_BITS'(MAX_MS);
                            result_valid <= 1'b1;
                            en_lfsr      <= 1'b1;
                        end else begin
                            ms_cnt <= ms_cnt + COUNT_BITS'(1);
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    ledr    <= '0;
                    en_lfsr <= 1'b1;
                end
            endcase
        end
    end

`ifndef RTC_BEST_TIME_EN
    assign best_ms = '0;
`endif

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
module tb_reaction_timer_ctrl;

    localparam int N     = 10;
    localparam int LB    = 5;
    localparam int CB    = 16;
    localparam int MAXMS = 9999;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tick_ms, tick_hs, trigger, react;
    logic [LB-1:0] prbs;
    logic          en_lfsr;
    logic [N-1:0]  ledr;
    logic [CB-1:0] reaction_ms;
    logic          result_valid, false_start;
    logic [CB-1:0] best_ms;

    int n_tests = 0;
    int n_fail  = 0;
    int model_best;

    reaction_timer_ctrl #(
        .N_LIGHTS   (N),
        .LFSR_BITS  (LB),
        .COUNT_BITS (CB),
        .MAX_MS     (MAXMS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick_ms      (tick_ms),
        .tick_hs      (tick_hs),
        .trigger      (trigger),
        .react        (react),
        .prbs         (prbs),
        .en_lfsr      (en_lfsr),
        .ledr         (ledr),
        .reaction_ms  (reaction_ms),
        .result_valid (result_valid),
        .false_start  (false_start),
        .best_ms      (best_ms)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pv;
        int r_ms;
        bit coin;
        int exp_ms;
        int exp_best;
    } run_t;

    run_t runs[5];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", nm, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_hs();
        tick_hs = 1'b1; tick_ms = 1'b1; cyc();
        tick_hs = 1'b0; tick_ms = 1'b0; cyc();
    endtask

    task automatic pulse_ms();
        tick_ms = 1'b1; cyc();
        tick_ms = 1'b0; cyc();
    endtask

    function automatic int exp_best_val(input int b);
`ifdef RTC_BEST_TIME_EN
        return b;
`else
        return 0;
`endif
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_ledr"}, 32'(ledr), 0);
        check({tag, "_en_lfsr"}, 32'(en_lfsr), 1);
        check({tag, "_reaction"}, 32'(reaction_ms), 0);
        check({tag, "_rv"}, 32'(result_valid), 0);
        check({tag, "_fs"}, 32'(false_start), 0);
        check({tag, "_best"}, 32'(best_ms), 32'(exp_best_val(32'hFFFF)));
    endtask

    // One game: r_ms >= 0 reacts after r_ms ticks, -1 lets the timer saturate,
    // -2 stops inside TIMING after a few ticks. fs_at >= 0 presses react before
    // the fs_at-th half-second tick (false start).
    task automatic do_run(input int pv, input int r_ms, input bit coin, input int fs_at,
                          input string tag);
        int d, hs_total, exp_l;
        d = (pv == 0) ? 1 : pv;
        hs_total = N + d;
        trigger = 1'b1; cyc(); trigger = 1'b0;
        check({tag, "_start_en_lfsr"}, 32'(en_lfsr), 0);
        check({tag, "_start_ledr"}, 32'(ledr), 0);
        check({tag, "_start_rv"}, 32'(result_valid), 0);
        check({tag, "_start_fs"}, 32'(false_start), 0);
        for (int i = 0; i < hs_total; i++) begin
            if (i == fs_at) begin
                react = 1'b1; cyc(); react = 1'b0; cyc();
                check({tag, "_fault_fs"}, 32'(false_start), 1);
                check({tag, "_fault_ledr"}, 32'(ledr), 32'h3FF);
                check({tag, "_fault_rv"}, 32'(result_valid), 0);
                check({tag, "_fault_en"}, 32'(en_lfsr), 1);
                return;
            end
            prbs = (i == N - 1) ? LB'(pv) : LB'($urandom);
            pulse_hs();
            if (i < N)                 exp_l = (1 << (i + 1)) - 1;
            else if (i < hs_total - 1) exp_l = 32'h3FF;
            else                       exp_l = 0;
            check($sformatf("%s_ledr_hs%0d", tag, i), 32'(ledr), 32'(exp_l));
            check($sformatf("%s_en_hs%0d", tag, i), 32'(en_lfsr), 0);
        end
        if (r_ms == -2) begin
            for (int k = 0; k < 5; k++) pulse_ms();
            return;
        end
        if (r_ms < 0) begin
            for (int k = 0; k < MAXMS; k++) begin
                pulse_ms();
                if (k == MAXMS - 2) check({tag, "_pre_sat_rv"}, 32'(result_valid), 0);
            end
        end else begin
            for (int k = 0; k < r_ms; k++) pulse_ms();
            react = 1'b1;
            if (coin) tick_ms = 1'b1;
            cyc();
            react = 1'b0; tick_ms = 1'b0;
            cyc();
            if (r_ms < model_best) model_best = r_ms;
        end
        check({tag, "_reaction"}, 32'(reaction_ms), 32'((r_ms < 0) ? MAXMS : r_ms));
        check({tag, "_rv"}, 32'(result_valid), 1);
        check({tag, "_fs"}, 32'(false_start), 0);
        check({tag, "_en"}, 32'(en_lfsr), 1);
        check({tag, "_ledr"}, 32'(ledr), 0);
        check({tag, "_best"}, 32'(best_ms), 32'(exp_best_val(model_best)));
    endtask

    initial begin
        rst_n = 1'b0; tick_ms = 1'b0; tick_hs = 1'b0;
        trigger = 1'b0; react = 1'b0; prbs = '0;
        model_best = 32'hFFFF;

        runs[0] = '{pv: 3, r_ms: 250, coin: 1'b0, exp_ms: 250,   exp_best: 250};
        runs[1] = '{pv: 0, r_ms: 300, coin: 1'b0, exp_ms: 300,   exp_best: 250};
        runs[2] = '{pv: 7, r_ms: 200, coin: 1'b1, exp_ms: 200,   exp_best: 200};
        runs[3] = '{pv: 1, r_ms: 400, coin: 1'b0, exp_ms: 400,   exp_best: 200};
        runs[4] = '{pv: 0, r_ms: -1,  coin: 1'b0, exp_ms: MAXMS, exp_best: 200};

        // Reset with trigger held: no start event may be seen afterwards.
        trigger = 1'b1;
        cyc(); cyc();
        check_reset_values("reset");
        rst_n = 1'b1;
        cyc(); cyc();
        check("held_trigger_idle", 32'(en_lfsr), 1);
        trigger = 1'b0;
        pulse_hs();
        check("idle_hs_ledr", 32'(ledr), 0);

        for (int t = 0; t < 5; t++) begin
            do_run(runs[t].pv, runs[t].r_ms, runs[t].coin, -1, $sformatf("tbl%0d", t));
            check($sformatf("tbl%0d_exp_ms", t), 32'(reaction_ms), 32'(runs[t].exp_ms));
            check($sformatf("tbl%0d_exp_best", t), 32'(best_ms), 32'(exp_best_val(runs[t].exp_best)));
        end

        // React in DONE is ignored.
        react = 1'b1; cyc(); react = 1'b0; cyc();
        check("done_react_rv", 32'(result_valid), 1);
        check("done_react_ms", 32'(reaction_ms), MAXMS);

        // Trigger and react together in DONE: trigger wins.
        trigger = 1'b1; react = 1'b1; cyc();
        trigger = 1'b0; react = 1'b0; cyc();
        check("done_both_en", 32'(en_lfsr), 0);
        check("done_both_fs", 32'(false_start), 0);
        check("done_both_rv", 32'(result_valid), 0);

        // Trigger and react together in LIGHTS: react wins -> FAULT.
        trigger = 1'b1; react = 1'b1; cyc();
        trigger = 1'b0; react = 1'b0; cyc();
        check("lights_both_fs", 32'(false_start), 1);
        check("lights_both_ledr", 32'(ledr), 32'h3FF);

        // False start in DELAY, then restart from FAULT.
        do_run(2, 0, 1'b0, N + 1, "fs_delay");
        do_run(2, 123, 1'b0, -1, "after_fault");

        // Reset in the middle of TIMING.
        do_run(4, -2, 1'b0, -1, "mid_timing");
        rst_n = 1'b0; cyc();
        model_best = 32'hFFFF;
        check_reset_values("mid_reset");
        rst_n = 1'b1; cyc();

        // Randomized games against the arithmetic model.
        for (int t = 0; t < 10; t++) begin
            int pv, d, fs_at, r;
            bit coin;
            pv    = $urandom_range(0, 31);
            d     = (pv == 0) ? 1 : pv;
            fs_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, N + d - 1) : -1;
            r     = $urandom_range(0, 400);
            coin  = 1'($urandom_range(0, 1));
            do_run(pv, r, coin, fs_at, $sformatf("rnd%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
